// File: rtl/sadd_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package sadd_pkg;

  // Operation sequencing: IDLE only after reset, DONE after a published result.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Digit counter width: enough bits to count WIDTH/DIGIT digits, never zero.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sadd_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice.
// c_top_o is the carry into the most significant bit of the slice; on the
// final digit it is the carry into the operand MSB and feeds signed overflow.
module sadd_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             c_top_o
);

  logic [DIGIT:0] c;

  assign c[0] = cin_i;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ c[gi];
      assign c[gi+1]   = (a_i[gi] & b_i[gi]) | (a_i[gi] & c[gi]) | (b_i[gi] & c[gi]);
    end
  endgenerate

  assign cout_o  = c[DIGIT];
  assign c_top_o = c[DIGIT-1];

endmodule

// File: rtl/sadd_serial_param.sv
// Parametrised digit-serial adder/subtractor, LSB digit first.
// Optional build macro SADD_SERIAL_SATURATE_EN: clamp pout to the signed
// extreme on overflow (cout/ovf stay unclamped).
module sadd_serial_param
  import sadd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pload,
  input  logic             enable,
  input  logic             sub,
  input  logic [WIDTH-1:0] adata,
  input  logic [WIDTH-1:0] bdata,
  output logic [WIDTH-1:0] pout,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("sadd_serial_param: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] pout_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
`ifdef SADD_SERIAL_SATURATE_EN
  logic             a_sign_q;
`endif

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_ctop;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] pout_d;
  logic             ovf_d;

  sadd_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout),
    .c_top_o(dig_ctop)
  );

  // Result register after this digit: new digit enters at the top.
  assign r_d   = (r_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  assign ovf_d = dig_ctop ^ dig_cout;

`ifdef SADD_SERIAL_SATURATE_EN
  // Clamp toward the sign of A: both operands share it whenever ovf is set.
  assign pout_d = ovf_d ? {a_sign_q, {(WIDTH-1){~a_sign_q}}} : r_d;
`else
  assign pout_d = r_d;
`endif

  // FSM, datapath shift registers and published output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      pout_q   <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SADD_SERIAL_SATURATE_EN
      a_sign_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // Digit step; the final digit also publishes the result.
      if (state_q == S_RUN && enable) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        r_q     <= r_d;
        carry_q <= dig_cout;
        cnt_q   <= cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          pout_q  <= pout_d;
          cout_q  <= dig_cout;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_DONE;
        end
      end
      // A load overrides any digit step on the same edge (publish still stands).
      if (pload) begin
        a_q      <= adata;
        b_q      <= sub ? ~bdata : bdata;
        r_q      <= '0;
        carry_q  <= sub;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
        state_q  <= S_RUN;
`ifdef SADD_SERIAL_SATURATE_EN
        a_sign_q <= adata[WIDTH-1];
`endif
      end
    end
  end

  assign pout = pout_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sadd_serial_param.sv
// Self-checking bench: WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4 instances,
// scoreboard queues filled at load time and drained on done.
module tb_sadd_serial_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pload8, en8, sub8;
  logic [7:0]  a8, b8, pout8;
  logic        cout8, ovf8, busy8, done8;
  logic        pload16, en16, sub16;
  logic [15:0] a16, b16, pout16;
  logic        cout16, ovf16, busy16, done16;

  sadd_serial_param #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .pload(pload8), .enable(en8), .sub(sub8),
    .adata(a8), .bdata(b8), .pout(pout8), .cout(cout8), .ovf(ovf8),
    .busy(busy8), .done(done8)
  );

  sadd_serial_param #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .pload(pload16), .enable(en16), .sub(sub16),
    .adata(a16), .bdata(b16), .pout(pout16), .cout(cout16), .ovf(ovf16),
    .busy(busy16), .done(done16)
  );

  typedef struct packed {
    logic [15:0] p;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done8_cnt = 0;
  int   done16_cnt = 0;

  always @(negedge clk) begin
    if (done8 === 1'b1) done8_cnt++;
    if (done16 === 1'b1) done16_cnt++;
  end

  // Reference model: plain wide addition of A, effective B and carry-in.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    logic [16:0] full;
    logic [15:0] mask, be, am;
    logic        sa, sb, sr;
    exp_t        e;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    am   = a & mask;
    be   = (s ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, be} + {16'd0, s};
    e.p  = full[15:0] & mask;
    e.c  = (w == 16) ? full[16] : full[8];
    sa   = am[w-1];
    sb   = be[w-1];
    sr   = e.p[w-1];
    e.o  = (sa == sb) && (sr != sa);
`ifdef SADD_SERIAL_SATURATE_EN
    if (e.o) e.p = sa ? (mask ^ (mask >> 1)) : (mask >> 1);
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic en, input bit push);
    a8 = a; b8 = b; sub8 = s; en8 = en; pload8 = 1'b1;
    if (push) q8.push_back(model(8, {8'd0, a}, {8'd0, b}, s));
    tick();
    pload8 = 1'b0; en8 = 1'b0;
  endtask

  task automatic run8(output int lat, output bit seen);
    lat = 0; seen = 1'b0; en8 = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      lat++;
      if (done8 === 1'b1) seen = 1'b1;
    end
    en8 = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if (pout8 !== 8'h00) begin n_fail++; $display("FAIL reset_pout: got %h want 00", pout8); end
    n_checks++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout8); end
    n_checks++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done8); end
    n_checks++; if (pout16 !== 16'h0000) begin n_fail++; $display("FAIL reset_pout16: got %h want 0000", pout16); end
    rst = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  // Table of 8-bit operations: basic add, carry/overflow and subtract cases.
  task automatic test_arith8();
    logic [7:0] ta[5] = '{8'hAA, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb[5] = '{8'h55, 8'h01, 8'h01, 8'h07, 8'h01};
    logic       ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat; bit seen; int d0; exp_t e;
    for (int i = 0; i < 5; i++) begin
      d0 = done8_cnt;
      load8(ta[i], tb[i], ts[i], 1'b0, 1'b1);
      run8(lat, seen);
      e = q8.pop_front();
      n_checks++; if (!seen || lat != 8) begin n_fail++; $display("FAIL arith8_latency[%0d]: got %0d (seen=%0b) want 8", i, lat, seen); end
      n_checks++; if (pout8 !== e.p[7:0]) begin n_fail++; $display("FAIL arith8_pout[%0d]: got %h want %h", i, pout8, e.p[7:0]); end
      n_checks++; if (cout8 !== e.c) begin n_fail++; $display("FAIL arith8_cout[%0d]: got %b want %b", i, cout8, e.c); end
      n_checks++; if (ovf8 !== e.o) begin n_fail++; $display("FAIL arith8_ovf[%0d]: got %b want %b", i, ovf8, e.o); end
      tick();
      n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL arith8_busy[%0d]: got %b want 0", i, busy8); end
      n_checks++; if (done8_cnt - d0 != 1) begin n_fail++; $display("FAIL arith8_donecount[%0d]: got %0d want 1", i, done8_cnt - d0); end
      $display("arith8 %h %s %h -> pout=%h cout=%b ovf=%b", ta[i], ts[i] ? "-" : "+", tb[i], pout8, cout8, ovf8);
    end
  endtask

  task automatic test_stall();
    logic [7:0] prev; int total, en_cnt; bit seen; exp_t e;
    prev = pout8; total = 0; en_cnt = 0; seen = 1'b0;
    load8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && !seen; i++) begin
      en8 = (i % 2 == 0);
      tick();
      total++;
      if (en8) en_cnt++;
      if (done8 === 1'b1) seen = 1'b1;
      else begin
        n_checks++; if (pout8 !== prev) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, pout8, prev); end
      end
    end
    en8 = 1'b0;
    e = q8.pop_front();
    n_checks++; if (!seen || total != 15 || en_cnt != 8) begin n_fail++; $display("FAIL stall_latency: got %0d cycles/%0d enabled want 15/8", total, en_cnt); end
    n_checks++; if (pout8 !== e.p[7:0]) begin n_fail++; $display("FAIL stall_pout: got %h want %h", pout8, e.p[7:0]); end
    $display("stall: 0x12+0x34 -> %h after %0d cycles", pout8, total);
    tick();
  endtask

  task automatic test_priority();
    int lat; bit seen; exp_t e;
    load8(8'h3A, 8'h27, 1'b0, 1'b1, 1'b1);
    run8(lat, seen);
    e = q8.pop_front();
    n_checks++; if (!seen || lat != 8) begin n_fail++; $display("FAIL priority_latency: got %0d want 8", lat); end
    n_checks++; if (pout8 !== e.p[7:0]) begin n_fail++; $display("FAIL priority_pout: got %h want %h", pout8, e.p[7:0]); end
    $display("priority: pload+enable -> latency %0d pout=%h", lat, pout8);
    tick();
  endtask

  task automatic test_abort();
    int lat, d0; bit seen; exp_t e;
    d0 = done8_cnt;
    load8(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    en8 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    en8 = 1'b0;
    load8(8'h3C, 8'h0F, 1'b1, 1'b0, 1'b1);
    run8(lat, seen);
    e = q8.pop_front();
    n_checks++; if (!seen || lat != 8) begin n_fail++; $display("FAIL abort_latency: got %0d want 8", lat); end
    n_checks++; if (pout8 !== e.p[7:0] || cout8 !== e.c) begin n_fail++; $display("FAIL abort_result: got %h/%b want %h/%b", pout8, cout8, e.p[7:0], e.c); end
    tick();
    n_checks++; if (done8_cnt - d0 != 1) begin n_fail++; $display("FAIL abort_donecount: got %0d want 1", done8_cnt - d0); end
    $display("abort: restarted 0x3C-0x0F -> %h", pout8);
  endtask

  task automatic test_back_to_back();
    int lat; bit seen; exp_t e;
    load8(8'h40, 8'h40, 1'b0, 1'b0, 1'b1);
    en8 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; pload8 = 1'b1;
    q8.push_back(model(8, 16'h0001, 16'h0002, 1'b0));
    tick();
    pload8 = 1'b0; en8 = 1'b0;
    e = q8.pop_front();
    n_checks++; if (done8 !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done8); end
    n_checks++; if (pout8 !== e.p[7:0] || ovf8 !== e.o) begin n_fail++; $display("FAIL b2b_first: got %h/%b want %h/%b", pout8, ovf8, e.p[7:0], e.o); end
    n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy8); end
    run8(lat, seen);
    e = q8.pop_front();
    n_checks++; if (!seen || lat != 8 || pout8 !== e.p[7:0]) begin n_fail++; $display("FAIL b2b_second: got %h lat %0d want %h lat 8", pout8, lat, e.p[7:0]); end
    $display("back_to_back: second result %h", pout8);
    tick();
  endtask

  task automatic test_async_reset();
    load8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    en8 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    en8 = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (pout8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin n_fail++; $display("FAIL async_reset_result: got %h/%b/%b want 00/0/0", pout8, cout8, ovf8); end
    n_checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got busy=%b done=%b want 0/0", busy8, done8); end
    #1 rst = 1'b1;
    tick();
    $display("async_reset: outputs cleared mid-cycle");
  endtask

  task automatic test_digit16();
    logic [15:0] ta[3] = '{16'h1234, 16'hFFFF, 16'h8000};
    logic [15:0] tb[3] = '{16'h0FCD, 16'h0001, 16'h0001};
    logic        ts[3] = '{1'b0, 1'b0, 1'b1};
    int lat; bit seen; exp_t e;
    for (int i = 0; i < 3; i++) begin
      a16 = ta[i]; b16 = tb[i]; sub16 = ts[i]; pload16 = 1'b1;
      q16.push_back(model(16, ta[i], tb[i], ts[i]));
      tick();
      pload16 = 1'b0; en16 = 1'b1; lat = 0; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick(); lat++;
        if (done16 === 1'b1) seen = 1'b1;
      end
      en16 = 1'b0;
      e = q16.pop_front();
      n_checks++; if (!seen || lat != 4) begin n_fail++; $display("FAIL digit16_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++; if (pout16 !== e.p || cout16 !== e.c || ovf16 !== e.o) begin n_fail++; $display("FAIL digit16_result[%0d]: got %h/%b/%b want %h/%b/%b", i, pout16, cout16, ovf16, e.p, e.c, e.o); end
      $display("digit16 %h %s %h -> pout=%h cout=%b ovf=%b", ta[i], ts[i] ? "-" : "+", tb[i], pout16, cout16, ovf16);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    pload8 = 1'b0; en8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    pload16 = 1'b0; en16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    #2 rst = 1'b0;
    test_reset();
    test_arith8();
    test_stall();
    test_priority();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_digit16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sadd_serial_param.md
Name: sadd_serial_param

Overview:
Parametrised digit-serial adder/subtractor, the successor to the fixed 8-bit bit-serial adder.
- Loads two WIDTH-bit operands in parallel and processes DIGIT bits per enabled cycle, LSB digit first.
- Adds or subtracts, and reports carry-out and signed overflow.
- Publishes each completed result atomically with a done pulse.
- Used as a low-area arithmetic unit wherever throughput is not critical.

Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per enabled cycle; WIDTH % DIGIT == 0 is required (checked by an elaboration-time assertion).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- pload  input  1  parallel load of operands; starts a new operation
- enable  input  1  advance one digit when running
- sub  input  1  sampled at pload: 0 = A+B, 1 = A−B
- adata  input  WIDTH  operand A
- bdata  input  WIDTH  operand B
- pout  output  WIDTH  last completed result
- cout  output  1  carry-out of last result (subtract: 1 = no borrow)
- ovf  output  1  signed overflow of last result
- busy  output  1  an operation is loaded and not yet complete
- done  output  1  one-cycle pulse when pout/cout/ovf update

Behaviour:
- Reset (rst = 0, asynchronous):
  - pout = 0, cout = 0, ovf = 0, busy = 0, done = 0.
  - State IDLE, internal shift registers, carry and digit counter cleared.
- States:
  - IDLE: after reset only.
  - RUN: operation in progress.
  - DONE: result published; otherwise behaves as IDLE.
- pload = 1 at an edge, any state:
  - A_sh ← adata.
  - B_sh ← bdata, or ~bdata when sub = 1.
  - carry ← sub.
  - Save sign bits adata[WIDTH−1] and effective B MSB.
  - cnt ← 0, state → RUN, busy = 1.
  - pload has priority over enable in the same cycle: no digit is processed that edge.
- RUN with enable = 1, per edge:
  - Add the low DIGIT bits of A_sh, B_sh and carry.
  - Shift A_sh and B_sh right by DIGIT.
  - Shift the sum digit into the top of R_sh.
  - carry ← digit carry-out; cnt++.
- RUN with enable = 0: hold all state (stall); there is no timeout.
- Completion, on the edge where cnt reaches WIDTH/DIGIT − 1 with enable = 1:
  - pout ← final R_sh; cout ← final carry.
  - ovf ← (carry into MSB) XOR (carry out of MSB).
  - done = 1 for exactly the following cycle; busy = 0; state → DONE.
- Latency is exactly WIDTH/DIGIT enabled cycles after pload.
- pout, cout and ovf never show partial results; they change only at completion or reset.
- enable in IDLE/DONE is ignored; outputs are held.
- pload during RUN aborts the current operation and restarts; no done is issued for the aborted operation.
- pload on the same edge as completion: the completing result is published (done pulses) and the new operation is loaded.
- Reset mid-RUN: immediate return to reset values; the operation is lost.
- Arithmetic is modulo 2^WIDTH; operands are treated as two's complement for ovf only.

Optional Feature:
- Macro SADD_SERIAL_SATURATE_EN.
- Defined:
  - On completion with ovf = 1, pout is clamped from the saved signs: A sign 0 → 0 followed by all 1s (max positive); A sign 1 → 1 followed by all 0s (min negative).
  - cout and ovf are reported unclamped.
- Undefined: pout is always the wrapped result. No saturation logic is synthesised.

Decomposition:
- Package sadd_pkg:
  - state enum {S_IDLE, S_RUN, S_DONE}.
  - Function computing counter width, $clog2(WIDTH/DIGIT) with a minimum of 1.
- One sub-module, sadd_digit:
  - Combinational DIGIT-bit ripple adder.
  - Outputs sum, carry-out, and carry into its top bit, used for ovf on the last digit.
- Top level holds the FSM, shift registers, counter and output registers.

Test Plan:
1. WIDTH=8, DIGIT=1: pload adata=0xAA, bdata=0x55, sub=0, then 8 enabled cycles → pout=0xFF, cout=0, ovf=0; done pulses once on the 8th enabled edge; busy low afterwards.
2. Carry and overflow cases:
   - 0xFF+0x01 → pout=0x00, cout=1, ovf=0.
   - 0x7F+0x01 → pout=0x80, ovf=1; with SATURATE_EN pout=0x7F.
3. Subtract cases:
   - sub=1, 0x05−0x07 → pout=0xFE, cout=0, ovf=0.
   - 0x80−0x01 → pout=0x7F, ovf=1; with SATURATE_EN pout=0x80.
4. Stalls: enable alternating 1/0 after loading 0x12+0x34 → pout stays at the previous value for 15 cycles, then becomes 0x46 on the 8th enabled edge.
5. Priority, abort and reset:
   - pload and enable high together → no digit is consumed; completion still after 8 further enabled cycles.
   - pload at cycle 4 of a run → no done for the aborted operation; new result correct.
   - rst low mid-run → all outputs 0 asynchronously, before the next clk edge.
6. WIDTH=16, DIGIT=4: 0x1234+0x0FCD → pout=0x2201, cout=0, done after exactly 4 enabled cycles.
